pipelined_carry_increment_subtractor: RTL

Two-stage pipelined signed subtractor computing Diff = A - B with the carry-increment structure (two half-width ripple sections plus increment correction), split across a register boundary. It is the inverse-operation companion to the team's carry-increment adder and feeds the ALU datapath. A valid/ready handshake on both sides supports backpressure. It reports unsigned borrow and signed overflow.

---
 rtl/pipelined_carry_increment_subtractor.sv | 125 ++++++++++++
 1 files changed

// File: rtl/pipelined_carry_increment_subtractor.sv
// Two-stage pipelined carry-increment subtractor: Diff = A - B (mod 2^N).
// Stage 1 computes both half-width sections independently (low section with
// the +1 carry-in of two's-complement subtraction, high section with carry-in
// 0). Stage 2 folds the low carry into the high half through an increment
// chain and derives Borrow/Overflow. Valid/ready handshake with backpressure.
module pipelined_carry_increment_subtractor #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Diff,
  output logic         Borrow,
  output logic         Overflow
);

  localparam int H = N / 2;

  // Handshake controls
  logic s1_valid;
  logic s2_valid;
  logic s1_load;
  logic s2_load;
  logic in_xfer;
  logic s12_xfer;

  // Stage 1 combinational sections
  logic [H:0]   lo_sum;
  logic [H:0]   hi_sum;

  // Stage 1 registers
  logic [H-1:0] s1_lo;
  logic         s1_clo;
  logic [H-1:0] s1_hi;
  logic         s1_chi;
  logic         s1_asign;
  logic         s1_bsign;

  // Stage 2 combinational increment/flags
  logic [H:0]   inc_sum;
  logic         cout;
  logic         ovf_next;

  // Pipeline advance conditions: a stage may load when it is empty or when
  // the stage downstream of it is draining this cycle.
  always_comb begin
    s2_load  = !s2_valid || out_ready;
    s1_load  = !s1_valid || s2_load;
    in_ready = s1_load;
    in_xfer  = in_valid && s1_load;
    s12_xfer = s2_load && s1_valid;
  end

  // Half-width ripple sections; +1 of A + ~B + 1 enters the low section only
  always_comb begin
    lo_sum = {1'b0, A[H-1:0]} + {1'b0, ~B[H-1:0]} + {{H{1'b0}}, 1'b1};
    hi_sum = {1'b0, A[N-1:H]} + {1'b0, ~B[N-1:H]};
  end

  // Stage 1 valid tracks in_valid whenever the stage is allowed to advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
    end
  end

  // Stage 1 data captures only on an accepted input transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_lo    <= '0;
      s1_clo   <= 1'b0;
      s1_hi    <= '0;
      s1_chi   <= 1'b0;
      s1_asign <= 1'b0;
      s1_bsign <= 1'b0;
    end else if (in_xfer) begin
      s1_lo    <= lo_sum[H-1:0];
      s1_clo   <= lo_sum[H];
      s1_hi    <= hi_sum[H-1:0];
      s1_chi   <= hi_sum[H];
      s1_asign <= A[N-1];
      s1_bsign <= B[N-1];
    end
  end

  // Increment correction of the high half and result flags
  always_comb begin
    inc_sum  = {1'b0, s1_hi} + {{H{1'b0}}, s1_clo};
    // c_hi and c_inc are mutually exclusive, but both paths must contribute
    cout     = s1_chi | inc_sum[H];
    ovf_next = (s1_asign != s1_bsign) && (inc_sum[H-1] != s1_asign);
  end

  // Stage 2 valid tracks stage 1 valid whenever the output may advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
    end
  end

  // Stage 2 result registers; held stable while stalled by out_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Diff     <= '0;
      Borrow   <= 1'b0;
      Overflow <= 1'b0;
    end else if (s12_xfer) begin
      Diff     <= {inc_sum[H-1:0], s1_lo};
      Borrow   <= ~cout;
      Overflow <= ovf_next;
    end
  end

  assign out_valid = s2_valid;

endmodule
